// File: rtl/somador4bits_checker_if.sv
// Operand/result bus between the 4-bit adder and its self-test checker.
// master = checker (drives operands), slave = adder (drives the sum).
interface somador4bits_checker_if #(
   parameter int WIDTH = 4
);
   logic [WIDTH-1:0] num1;
   logic [WIDTH-1:0] num2;
   logic [WIDTH:0]   resultado;

   modport master (output num1, output num2, input resultado);
   modport slave  (input num1, input num2, output resultado);
endinterface

// File: rtl/somador4bits_checker.sv
// Exhaustive stimulus/response checker for the WIDTH-bit adder: walks every operand pair,
// counts mismatches and captures the first failing vector. Optional LFSR mode: SOMADOR_CHECKER_LFSR_EN.
module somador4bits_checker #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 9
`ifdef SOMADOR_CHECKER_LFSR_EN
   ,
   parameter int N_RAND = 64
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
`ifdef SOMADOR_CHECKER_LFSR_EN
   input  logic                   rand_mode,
`endif
   somador4bits_checker_if.master bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [ERR_W-1:0]       err_count,
   output logic [WIDTH-1:0]       fail_num1,
   output logic [WIDTH-1:0]       fail_num2,
   output logic [WIDTH:0]         fail_resultado
);

   localparam int VW          = 2 * WIDTH;
   localparam int SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE,
      APPLY,
      CHECK,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [VW-1:0]    vec_q;
   logic [VW-1:0]    vec_next;
   logic [VW-1:0]    vec_first;
   logic [SW-1:0]    settle_q;
   logic             found_q;
   logic             last_vec;
   logic             launch;
   logic [WIDTH:0]   expected;
   logic             mismatch;

   assign bus.num1 = vec_q[VW-1:WIDTH];
   assign bus.num2 = vec_q[WIDTH-1:0];

   assign expected = {1'b0, vec_q[VW-1:WIDTH]} + {1'b0, vec_q[WIDTH-1:0]};
   assign mismatch = (bus.resultado != expected);
   assign launch   = start && (state_q == IDLE || state_q == DONE);

   assign busy = (state_q == APPLY) || (state_q == CHECK);
   assign done = (state_q == DONE);
   assign pass = done && (err_count == '0);

`ifdef SOMADOR_CHECKER_LFSR_EN
   localparam int RW = $clog2(N_RAND + 1);

   // Fibonacci tap masks (bit k-1 set for polynomial term x^k) of maximal-length polynomials.
   function automatic logic [63:0] lfsr_mask(input int n);
      case (n)
         4:       lfsr_mask = 64'hC;
         6:       lfsr_mask = 64'h30;
         10:      lfsr_mask = 64'h240;
         12:      lfsr_mask = 64'h829;
         16:      lfsr_mask = 64'hD008;
         default: lfsr_mask = 64'hB8;
      endcase
   endfunction

   localparam logic [VW-1:0] LFSR_MASK = VW'(lfsr_mask(VW));

   logic          rand_q;
   logic [RW-1:0] rand_cnt_q;
   logic [VW-1:0] lfsr_next;

   assign lfsr_next = {vec_q[VW-2:0], ^(vec_q & LFSR_MASK)};
   assign vec_next  = rand_q ? lfsr_next : vec_q + VW'(1);
   assign vec_first = rand_mode ? VW'(1) : '0;
   assign last_vec  = rand_q ? (rand_cnt_q == RW'(N_RAND - 1)) : (vec_q == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         rand_q     <= 1'b0;
         rand_cnt_q <= '0;
      end else if (launch) begin
         rand_q     <= rand_mode;
         rand_cnt_q <= '0;
      end else if (state_q == CHECK && !last_vec) begin
         rand_cnt_q <= rand_cnt_q + RW'(1);
      end
   end
`else
   assign vec_next  = vec_q + VW'(1);
   assign vec_first = '0;
   assign last_vec  = (vec_q == '1);
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = APPLY;
         APPLY:      if (settle_q == SETTLE_LAST) state_d = CHECK;
         CHECK:      state_d = last_vec ? DONE : APPLY;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vec_q          <= '0;
         settle_q       <= '0;
         found_q        <= 1'b0;
         err_count      <= '0;
         fail_num1      <= '0;
         fail_num2      <= '0;
         fail_resultado <= '0;
      end else if (launch) begin
         vec_q          <= vec_first;
         settle_q       <= '0;
         found_q        <= 1'b0;
         err_count      <= '0;
         fail_num1      <= '0;
         fail_num2      <= '0;
         fail_resultado <= '0;
      end else begin
         if (state_q == APPLY)
            settle_q <= (settle_q == SETTLE_LAST) ? '0 : settle_q + SW'(1);
         if (state_q == CHECK) begin
            if (mismatch) begin
               if (err_count != '1) err_count <= err_count + ERR_W'(1);
               if (!found_q) begin
                  found_q        <= 1'b1;
                  fail_num1      <= vec_q[VW-1:WIDTH];
                  fail_num2      <= vec_q[WIDTH-1:0];
                  fail_resultado <= bus.resultado;
               end
            end
            // The final vector stays on the bus through DONE; the counter never wraps.
            if (!last_vec) vec_q <= vec_next;
         end
      end
   end

endmodule

// File: tb/tb_somador4bits_checker.sv
// Scoreboard bench for somador4bits_checker: a configurable (faulty) adder model feeds the
// checker; each run's expected verdict is computed up front and checked when done rises.
module tb_somador4bits_checker;

   localparam int WIDTH   = 4;
   localparam int SETTLE  = 1;
   localparam int ERR_W   = 9;
   localparam int NVEC    = 256;
   localparam int RUN_CYC = NVEC * (SETTLE + 1);

   typedef struct {
      int               start_cyc;
      logic [ERR_W-1:0] err;
      logic             pass;
      logic [3:0]       f1;
      logic [3:0]       f2;
      logic [4:0]       fr;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             rand_mode = 1'b0;
   logic             busy, done, pass;
   logic [ERR_W-1:0] err_count;
   logic [WIDTH-1:0] fail_num1, fail_num2;
   logic [WIDTH:0]   fail_resultado;

   int               fault_mode = 0;
   logic [3:0]       fa = '0, fb = '0;
   logic [4:0]       fx = '0;
   int               cyc = 0;
   int               total = 0;
   int               bad = 0;
   exp_t             q[$];

   somador4bits_checker_if #(.WIDTH(WIDTH)) bus ();

   somador4bits_checker #(
      .WIDTH (WIDTH),
      .SETTLE(SETTLE),
      .ERR_W (ERR_W)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
`ifdef SOMADOR_CHECKER_LFSR_EN
      .rand_mode     (rand_mode),
`endif
      .bus           (bus),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .fail_num1     (fail_num1),
      .fail_num2     (fail_num2),
      .fail_resultado(fail_resultado)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Adder under test: 0 ideal, 1 carry-out stuck at 0, 2 off by +1, 3 one corrupted pair.
   function automatic logic [4:0] adder(input int mode, input logic [3:0] a, input logic [3:0] b,
                                        input logic [3:0] ca, input logic [3:0] cb, input logic [4:0] x);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (mode)
         1:       adder = {1'b0, s[3:0]};
         2:       adder = s + 5'd1;
         3:       adder = (a == ca && b == cb) ? (s ^ x) : s;
         default: adder = s;
      endcase
   endfunction

   assign bus.resultado = adder(fault_mode, bus.num1, bus.num2, fa, fb, fx);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_pass"}, 32'(pass), 0);
      chk({tag, "_err"}, 32'(err_count), 0);
      chk({tag, "_fnum1"}, 32'(fail_num1), 0);
      chk({tag, "_fnum2"}, 32'(fail_num2), 0);
      chk({tag, "_fres"}, 32'(fail_resultado), 0);
      chk({tag, "_num1"}, 32'(bus.num1), 0);
      chk({tag, "_num2"}, 32'(bus.num2), 0);
   endtask

   // Reference verdict: walk all operand pairs in plain arithmetic, then launch the run.
   task automatic issue_run(input int mode);
      exp_t e;
      int   n;
      bit   found;
      logic [4:0] got;
      n = 0;
      found = 0;
      e.f1 = '0; e.f2 = '0; e.fr = '0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            got = adder(mode, a[3:0], b[3:0], fa, fb, fx);
            if (int'(got) != a + b) begin
               n++;
               if (!found) begin
                  found = 1;
                  e.f1 = a[3:0]; e.f2 = b[3:0]; e.fr = got;
               end
            end
         end
      end
      e.err  = ERR_W'(n);
      e.pass = (n == 0);
      fault_mode = mode;
      e.start_cyc = cyc;
      q.push_back(e);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("start_busy", 32'(busy), 1);
      chk("start_done_clr", 32'(done), 0);
      chk("start_err_clr", 32'(err_count), 0);
   endtask

   // Waits for done with a cycle bound, pulsing start at p1/p2 while the run is busy.
   task automatic wait_done(input int p1, input int p2);
      bit seen;
      seen = 0;
      for (int i = 0; i < RUN_CYC + 20; i++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
         start = (i == p1 || i == p2);
      end
      start = 1'b0;
      if (!seen) begin
         chk("done_timeout", 0, 1);
         if (q.size() > 0) void'(q.pop_front());
      end
   endtask

   // Monitor: checks the vector walk while busy and the verdict when done rises.
   initial begin : monitor
      exp_t e;
      int   idx;
      bit   done_prev;
      done_prev = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            done_prev = 0;
         end else begin
            if (busy && q.size() > 0) begin
               idx = (cyc - q[0].start_cyc - 1) / (SETTLE + 1);
               chk("vector", {24'b0, bus.num1, bus.num2}, 32'(idx));
            end
            if (done && !done_prev && q.size() > 0) begin
               e = q.pop_front();
               chk("latency", 32'(cyc - e.start_cyc - 1), RUN_CYC);
               chk("err_count", 32'(err_count), 32'(e.err));
               chk("pass", 32'(pass), 32'(e.pass));
               chk("fail_num1", 32'(fail_num1), 32'(e.f1));
               chk("fail_num2", 32'(fail_num2), 32'(e.f2));
               chk("fail_resultado", 32'(fail_resultado), 32'(e.fr));
               chk("busy_at_done", 32'(busy), 0);
               chk("hold_num1", 32'(bus.num1), 15);
               chk("hold_num2", 32'(bus.num2), 15);
            end
            done_prev = done;
         end
      end
   end

   initial begin : stimulus
      bit hit;
      rst   = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_idle_zero("idle");

      issue_run(0); wait_done(10, 200);
      issue_run(1); wait_done(-1, -1);
      issue_run(2); wait_done(-1, -1);
      for (int r = 0; r < 4; r++) begin
         fa = 4'($urandom_range(0, 15));
         fb = 4'($urandom_range(0, 15));
         fx = 5'($urandom_range(1, 31));
         issue_run(int'($urandom_range(0, 3)));
         wait_done(int'($urandom_range(0, RUN_CYC - 20)), int'($urandom_range(0, RUN_CYC - 20)));
      end

      // Abort a run at vector (6,4); start in the reset cycle must lose to rst.
      issue_run(0);
      hit = 0;
      for (int i = 0; i < RUN_CYC + 20; i++) begin
         if (bus.num1 == 4'd6 && bus.num2 == 4'd4) begin
            hit = 1;
            break;
         end
         @(negedge clk);
      end
      chk("reach_6_4", 32'(hit), 1);
      if (q.size() > 0) void'(q.pop_back());
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst   = 1'b0;
      start = 1'b0;
      check_idle_zero("midrun_rst");
      @(negedge clk);
      chk("rst_wins_busy", 32'(busy), 0);
      issue_run(0); wait_done(-1, -1);
      @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
